// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the 5-stage RV32I pipeline: tracks EX/MEM/WB
// destination shadows and drives enables, flushes, operand forwarding selects and perf counters.
module pipe_hazard_unit #(
   parameter int REG_AW    = 5,
   parameter int FWD_EN    = 1,
   parameter int WB_BYPASS = 1,
   parameter int CNT_W     = 32
) (
   input  logic              CLOCK,
   input  logic              RST_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              mem_redirect,
   input  logic              ext_stall,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              idex_en,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic              exmem_flush,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic FWD   = (FWD_EN != 0);
   localparam logic WB_HZ = (WB_BYPASS == 0);

   typedef struct packed {
      logic              valid;
      logic              regwrite;
      logic              memread;
      logic              use_rs1;
      logic              use_rs2;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
   } inst_t;

   // Past EX only the destination side is ever consulted.
   typedef struct packed {
      logic              valid;
      logic              regwrite;
      logic [REG_AW-1:0] rd;
   } dest_t;

   inst_t id_sh;
   inst_t ex_sh_p0;
   dest_t ex_dest;
   dest_t mem_sh_p1;
   dest_t wb_sh_p2;

   logic hit_ex, hit_mem, hit_wb, hazard_stall;

   function automatic logic src_match(input dest_t stg, input logic [REG_AW-1:0] src,
                                      input logic use_src);
      return use_src && stg.valid && stg.regwrite && (stg.rd == src) && (src != '0);
   endfunction

   function automatic logic [1:0] fwd_pick(input dest_t mem_d, input dest_t wb_d,
                                           input logic [REG_AW-1:0] src, input logic use_src);
      if (src_match(mem_d, src, use_src))
         return 2'b10;
      else if (src_match(wb_d, src, use_src))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // An empty ID slot is carried as an all-zero bubble so it can never match.
   always_comb begin
      id_sh = '0;
      if (id_valid) begin
         id_sh.valid    = 1'b1;
         id_sh.regwrite = id_regwrite;
         id_sh.memread  = id_memread;
         id_sh.use_rs1  = id_use_rs1;
         id_sh.use_rs2  = id_use_rs2;
         id_sh.rd       = id_rd;
         id_sh.rs1      = id_rs1;
         id_sh.rs2      = id_rs2;
      end
   end

   assign ex_dest = '{valid: ex_sh_p0.valid, regwrite: ex_sh_p0.regwrite, rd: ex_sh_p0.rd};

   always_comb begin
      hit_ex  = src_match(ex_dest, id_sh.rs1, id_sh.use_rs1) |
                src_match(ex_dest, id_sh.rs2, id_sh.use_rs2);
      hit_mem = src_match(mem_sh_p1, id_sh.rs1, id_sh.use_rs1) |
                src_match(mem_sh_p1, id_sh.rs2, id_sh.use_rs2);
      hit_wb  = src_match(wb_sh_p2, id_sh.rs1, id_sh.use_rs1) |
                src_match(wb_sh_p2, id_sh.rs2, id_sh.use_rs2);
      if (FWD)
         hazard_stall = id_sh.valid & ((hit_ex & ex_sh_p0.memread) | (WB_HZ & hit_wb));
      else
         hazard_stall = id_sh.valid & (hit_ex | hit_mem | (WB_HZ & hit_wb));
   end

   // Freeze beats redirect beats ID stall; a redirect squashes the stalled ID instruction.
   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      if (ext_stall) begin
         pc_en   = 1'b0;
         ifid_en = 1'b0;
         idex_en = 1'b0;
      end else if (mem_redirect) begin
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
      end else if (hazard_stall) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end
   end

   always_comb begin
      fwd_a_sel = 2'b00;
      fwd_b_sel = 2'b00;
      if (FWD) begin
         fwd_a_sel = fwd_pick(mem_sh_p1, wb_sh_p2, ex_sh_p0.rs1, ex_sh_p0.use_rs1);
         fwd_b_sel = fwd_pick(mem_sh_p1, wb_sh_p2, ex_sh_p0.rs2, ex_sh_p0.use_rs2);
      end
   end

   // ---- ID -> EX(_p0) -> MEM(_p1) -> WB(_p2) shadow advance ----
   always_ff @(posedge CLOCK or negedge RST_n) begin
      if (!RST_n) begin
         ex_sh_p0  <= '0;
         mem_sh_p1 <= '0;
         wb_sh_p2  <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (!ext_stall) begin
         ex_sh_p0  <= idex_flush ? '0 : id_sh;
         mem_sh_p1 <= exmem_flush ? '0 : ex_dest;
         wb_sh_p2  <= mem_sh_p1;
         if (exmem_flush)
            flush_cnt <= sat_inc(flush_cnt);
         else if (idex_flush)
            stall_cnt <= sat_inc(stall_cnt);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: three configurations driven by shared stimulus, checked every
// cycle against an instruction-level pipeline model, plus directed literal scenarios.
module tb_pipe_hazard_unit;

   localparam int FWD_P[3] = '{1, 0, 1};
   localparam int WBB_P[3] = '{1, 1, 0};
   localparam int CW_P[3]  = '{32, 4, 32};

   logic CLOCK = 1'b0;
   logic RST_n = 1'b0;
   logic id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
   logic id_regwrite = 1'b0, id_memread = 1'b0, mem_redirect = 1'b0, ext_stall = 1'b0;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;

   logic [2:0] pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush;
   logic [1:0] fa0, fa1, fa2, fb0, fb1, fb2;
   logic [31:0] sc0, sc2, fc0, fc2;
   logic [3:0]  sc1, fc1;

   int checks = 0;
   int failures = 0;

   always #5 CLOCK = ~CLOCK;

   pipe_hazard_unit #(.REG_AW(5), .FWD_EN(1), .WB_BYPASS(1), .CNT_W(32)) u0 (
      .CLOCK(CLOCK), .RST_n(RST_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .mem_redirect(mem_redirect), .ext_stall(ext_stall),
      .pc_en(pc_en[0]), .ifid_en(ifid_en[0]), .idex_en(idex_en[0]), .ifid_flush(ifid_flush[0]),
      .idex_flush(idex_flush[0]), .exmem_flush(exmem_flush[0]), .fwd_a_sel(fa0), .fwd_b_sel(fb0),
      .stall_cnt(sc0), .flush_cnt(fc0));

   pipe_hazard_unit #(.REG_AW(5), .FWD_EN(0), .WB_BYPASS(1), .CNT_W(4)) u1 (
      .CLOCK(CLOCK), .RST_n(RST_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .mem_redirect(mem_redirect), .ext_stall(ext_stall),
      .pc_en(pc_en[1]), .ifid_en(ifid_en[1]), .idex_en(idex_en[1]), .ifid_flush(ifid_flush[1]),
      .idex_flush(idex_flush[1]), .exmem_flush(exmem_flush[1]), .fwd_a_sel(fa1), .fwd_b_sel(fb1),
      .stall_cnt(sc1), .flush_cnt(fc1));

   pipe_hazard_unit #(.REG_AW(5), .FWD_EN(1), .WB_BYPASS(0), .CNT_W(32)) u2 (
      .CLOCK(CLOCK), .RST_n(RST_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .mem_redirect(mem_redirect), .ext_stall(ext_stall),
      .pc_en(pc_en[2]), .ifid_en(ifid_en[2]), .idex_en(idex_en[2]), .ifid_flush(ifid_flush[2]),
      .idex_flush(idex_flush[2]), .exmem_flush(exmem_flush[2]), .fwd_a_sel(fa2), .fwd_b_sel(fb2),
      .stall_cnt(sc2), .flush_cnt(fc2));

   // ---------------- reference model ----------------
   typedef struct {
      logic       valid, rw, mr, u1, u2;
      logic [4:0] rd, rs1, rs2;
   } ins_t;

   ins_t   pipe[3][3];          // [instance][0=EX,1=MEM,2=WB]
   longint scm[3], fcm[3];

   function automatic ins_t bubble();
      ins_t b;
      b = '{valid: 1'b0, rw: 1'b0, mr: 1'b0, u1: 1'b0, u2: 1'b0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0};
      return b;
   endfunction

   function automatic ins_t cur_id();
      ins_t i;
      i = bubble();
      if (id_valid)
         i = '{valid: 1'b1, rw: id_regwrite, mr: id_memread, u1: id_use_rs1, u2: id_use_rs2,
               rd: id_rd, rs1: id_rs1, rs2: id_rs2};
      return i;
   endfunction

   function automatic bit writes(ins_t p, logic [4:0] r);
      return p.valid && p.rw && (p.rd == r) && (r != 5'd0);
   endfunction

   function automatic bit src_stall(int k, logic [4:0] r);
      bit st = 0;
      if (FWD_P[k] != 0) begin
         if (writes(pipe[k][0], r) && pipe[k][0].mr) st = 1;
         if (WBB_P[k] == 0 && writes(pipe[k][2], r)) st = 1;
      end else begin
         for (int d = 0; d < 3; d++)
            if (writes(pipe[k][d], r) && (d < 2 || WBB_P[k] == 0)) st = 1;
      end
      return st;
   endfunction

   function automatic bit id_stall(int k);
      ins_t i;
      bit st = 0;
      i = cur_id();
      if (i.valid && i.u1 && src_stall(k, i.rs1)) st = 1;
      if (i.valid && i.u2 && src_stall(k, i.rs2)) st = 1;
      return st;
   endfunction

   // Nearest older producer of r wins: MEM -> 10, WB -> 01.
   function automatic logic [1:0] fwd_exp(int k, logic [4:0] r, logic u);
      if (FWD_P[k] == 0 || !u) return 2'b00;
      for (int d = 1; d < 3; d++)
         if (writes(pipe[k][d], r)) return (d == 1) ? 2'b10 : 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [9:0] exp_ctl(int k);
      logic [5:0] c;
      if (ext_stall)         c = 6'b000_000;
      else if (mem_redirect) c = 6'b111_111;
      else if (id_stall(k))  c = 6'b001_010;
      else                   c = 6'b111_000;
      return {c, fwd_exp(k, pipe[k][0].rs1, pipe[k][0].u1), fwd_exp(k, pipe[k][0].rs2, pipe[k][0].u2)};
   endfunction

   function automatic logic [1:0] obs_fa(int k);
      case (k) 0: return fa0; 1: return fa1; default: return fa2; endcase
   endfunction

   function automatic logic [1:0] obs_fb(int k);
      case (k) 0: return fb0; 1: return fb1; default: return fb2; endcase
   endfunction

   function automatic longint obs_sc(int k);
      case (k) 0: return longint'(sc0); 1: return longint'(sc1); default: return longint'(sc2); endcase
   endfunction

   function automatic longint obs_fc(int k);
      case (k) 0: return longint'(fc0); 1: return longint'(fc1); default: return longint'(fc2); endcase
   endfunction

   function automatic logic [9:0] obs_ctl(int k);
      return {pc_en[k], ifid_en[k], idex_en[k], ifid_flush[k], idex_flush[k], exmem_flush[k],
              obs_fa(k), obs_fb(k)};
   endfunction

   function automatic longint sat_max(int k);
      return longint'((64'd1 << CW_P[k]) - 64'd1);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         for (int d = 0; d < 3; d++) pipe[k][d] = bubble();
         scm[k] = 0;
         fcm[k] = 0;
      end
   endtask

   // Compare process: check at negedge, advance the model at the following posedge.
   initial begin
      ins_t   npipe[3][3];
      longint nsc[3], nfc[3];
      model_reset();
      forever begin
         @(negedge CLOCK);
         if (!RST_n) model_reset();
         for (int k = 0; k < 3; k++) begin
            logic [9:0] e, g;
            e = exp_ctl(k);
            g = obs_ctl(k);
            checks++;
            if (g !== e) begin
               failures++;
               $display("FAIL ctl inst%0d t=%0t got=%b expected=%b", k, $time, g, e);
            end
            checks++;
            if (obs_sc(k) != scm[k]) begin
               failures++;
               $display("FAIL stall_cnt inst%0d t=%0t got=%0d expected=%0d", k, $time, obs_sc(k), scm[k]);
            end
            checks++;
            if (obs_fc(k) != fcm[k]) begin
               failures++;
               $display("FAIL flush_cnt inst%0d t=%0t got=%0d expected=%0d", k, $time, obs_fc(k), fcm[k]);
            end
         end
         for (int k = 0; k < 3; k++) begin
            for (int d = 0; d < 3; d++) npipe[k][d] = pipe[k][d];
            nsc[k] = scm[k];
            nfc[k] = fcm[k];
            if (!RST_n) begin
               for (int d = 0; d < 3; d++) npipe[k][d] = bubble();
               nsc[k] = 0;
               nfc[k] = 0;
            end else if (!ext_stall) begin
               npipe[k][2] = pipe[k][1];
               if (mem_redirect) begin
                  npipe[k][1] = bubble();
                  npipe[k][0] = bubble();
                  if (fcm[k] < sat_max(k)) nfc[k] = fcm[k] + 1;
               end else if (id_stall(k)) begin
                  npipe[k][1] = pipe[k][0];
                  npipe[k][0] = bubble();
                  if (scm[k] < sat_max(k)) nsc[k] = scm[k] + 1;
               end else begin
                  npipe[k][1] = pipe[k][0];
                  npipe[k][0] = cur_id();
               end
            end
         end
         @(posedge CLOCK);
         for (int k = 0; k < 3; k++) begin
            for (int d = 0; d < 3; d++) pipe[k][d] = npipe[k][d];
            scm[k] = nsc[k];
            fcm[k] = nfc[k];
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic chk(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK);
      #2;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                         input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2);
      id_valid = v; id_rd = rd; id_regwrite = rw; id_memread = mr;
      id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
   endtask

   task automatic nop();
      set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
   endtask

   task automatic do_reset();
      tick();
      RST_n = 1'b0;
      nop();
      mem_redirect = 1'b0;
      ext_stall = 1'b0;
      #1;
      chk("reset_pc_en", pc_en[0], 1);
      chk("reset_stall_cnt", sc0, 0);
      tick();
      RST_n = 1'b1;
   endtask

   initial begin
      nop();
      do_reset();

      // lw x5,0(x1); add x6,x5,x2
      set_id(1, 5'd5, 1, 1, 5'd1, 1, 5'd0, 0);
      tick(); set_id(1, 5'd6, 1, 0, 5'd5, 1, 5'd2, 1); #1;
      chk("lu_pc_en", pc_en[0], 0);
      chk("lu_ifid_en", ifid_en[0], 0);
      chk("lu_idex_en", idex_en[0], 1);
      chk("lu_idex_flush", idex_flush[0], 1);
      tick(); #1;
      chk("lu_release_pc_en", pc_en[0], 1);
      chk("lu_stall_cnt", sc0, 1);
      tick(); nop(); #1;
      chk("lu_fwd_a", fa0, 1);
      chk("lu_fwd_b", fb0, 0);

      // add x5,x1,x2; sub x7,x5,x5
      do_reset();
      set_id(1, 5'd5, 1, 0, 5'd1, 1, 5'd2, 1);
      tick(); set_id(1, 5'd7, 1, 0, 5'd5, 1, 5'd5, 1); #1;
      chk("alu_no_stall", pc_en[0], 1);
      tick(); nop(); #1;
      chk("alu_fwd_a", fa0, 2);
      chk("alu_fwd_b", fb0, 2);

      // add x5; add x5; or x8,x5,x0
      do_reset();
      set_id(1, 5'd5, 1, 0, 5'd1, 1, 5'd2, 1);
      tick(); set_id(1, 5'd5, 1, 0, 5'd3, 1, 5'd4, 1);
      tick(); set_id(1, 5'd8, 1, 0, 5'd5, 1, 5'd0, 1);
      tick(); nop(); #1;
      chk("newest_fwd_a", fa0, 2);
      chk("x0_fwd_b", fb0, 0);

      // redirect while a load-use stall is pending
      do_reset();
      set_id(1, 5'd5, 1, 1, 5'd1, 1, 5'd0, 0);
      tick(); set_id(1, 5'd6, 1, 0, 5'd5, 1, 5'd2, 1); mem_redirect = 1; #1;
      chk("rd_ifid_flush", ifid_flush[0], 1);
      chk("rd_idex_flush", idex_flush[0], 1);
      chk("rd_exmem_flush", exmem_flush[0], 1);
      chk("rd_pc_en", pc_en[0], 1);
      tick(); mem_redirect = 0; nop(); #1;
      chk("rd_stall_cnt", sc0, 0);
      chk("rd_flush_cnt", fc0, 1);

      // ext_stall held 3 cycles over a redirect
      do_reset();
      mem_redirect = 1; ext_stall = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("frz_pc_en", pc_en[0], 0);
         chk("frz_idex_en", idex_en[0], 0);
         chk("frz_flush", ifid_flush[0], 0);
         tick();
      end
      ext_stall = 0; #1;
      chk("frz_release_flush", exmem_flush[0], 1);
      chk("frz_flush_cnt_hold", fc0, 0);
      tick(); mem_redirect = 0; #1;
      chk("frz_flush_cnt", fc0, 1);

      // stall-only config: add x5; add x6,x5,x5 -> two stall cycles
      do_reset();
      set_id(1, 5'd5, 1, 0, 5'd1, 1, 5'd2, 1);
      tick(); set_id(1, 5'd6, 1, 0, 5'd5, 1, 5'd5, 1); #1;
      chk("nofwd_stall_ex", pc_en[1], 0);
      tick(); #1;
      chk("nofwd_stall_mem", pc_en[1], 0);
      tick(); #1;
      chk("nofwd_release", pc_en[1], 1);
      chk("nofwd_stall_cnt", sc1, 2);

      // writes to x0 never stall
      do_reset();
      set_id(1, 5'd0, 1, 0, 5'd1, 1, 5'd2, 1);
      tick(); set_id(1, 5'd6, 1, 0, 5'd0, 1, 5'd0, 1); #1;
      chk("x0_no_stall_ex", pc_en[1], 1);
      tick(); #1;
      chk("x0_no_stall_mem", pc_en[1], 1);

      // no WB bypass: producer three ahead still hazards
      do_reset();
      set_id(1, 5'd5, 1, 0, 5'd1, 1, 5'd2, 1);
      tick(); nop();
      tick();
      tick(); set_id(1, 5'd6, 1, 0, 5'd5, 1, 5'd0, 0); #1;
      chk("wb_hazard", pc_en[2], 0);
      chk("wb_bypass_ok", pc_en[0], 1);

      // randomized traffic, checked every cycle by the model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         tick();
         if (!RST_n) RST_n = 1'b1;
         if ($urandom_range(0, 399) == 0) begin
            RST_n = 1'b0;
            nop();
            mem_redirect = 0;
            ext_stall = 0;
         end else begin
            set_id($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                   5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
            mem_redirect = $urandom_range(0, 11) == 0;
            ext_stall = $urandom_range(0, 9) == 0;
         end
      end
      tick();
      RST_n = 1'b1;
      nop();
      mem_redirect = 0;
      ext_stall = 0;
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
